// File: rtl/sprite_layer_mapper_if.sv
// ----------------------------------------------------------------------------
// sprite_layer_mapper_if
// Pixel-stream bundle between the sprite/bullet logic (master) and the
// sprite_layer_mapper (slave).
//   master drives : DrawX, DrawY, pixel_valid, frame_start, hit_pulse,
//                   layer_on, layer_color, bullet_active, bulletX, bulletY,
//                   bullet_color, bg_color
//   slave drives  : Red, Green, Blue, rgb_valid, blinking
// layer_color / bulletX / bulletY are packed per slot, slot i in the i-th
// field counted from bit 0.
// ----------------------------------------------------------------------------
interface sprite_layer_mapper_if #(
    parameter int NUM_LAYERS  = 4,
    parameter int NUM_BULLETS = 4
);
    logic [9:0]                 DrawX;
    logic [9:0]                 DrawY;
    logic                       pixel_valid;
    logic                       frame_start;
    logic                       hit_pulse;
    logic [NUM_LAYERS-1:0]      layer_on;
    logic [24*NUM_LAYERS-1:0]   layer_color;
    logic [NUM_BULLETS-1:0]     bullet_active;
    logic [10*NUM_BULLETS-1:0]  bulletX;
    logic [10*NUM_BULLETS-1:0]  bulletY;
    logic [23:0]                bullet_color;
    logic [23:0]                bg_color;
    logic [7:0]                 Red;
    logic [7:0]                 Green;
    logic [7:0]                 Blue;
    logic                       rgb_valid;
    logic                       blinking;

    modport master (
        output DrawX, DrawY, pixel_valid, frame_start, hit_pulse,
               layer_on, layer_color, bullet_active, bulletX, bulletY,
               bullet_color, bg_color,
        input  Red, Green, Blue, rgb_valid, blinking
    );

    modport slave (
        input  DrawX, DrawY, pixel_valid, frame_start, hit_pulse,
               layer_on, layer_color, bullet_active, bulletX, bulletY,
               bullet_color, bg_color,
        output Red, Green, Blue, rgb_valid, blinking
    );
endinterface

// File: rtl/sprite_layer_mapper.sv
// ----------------------------------------------------------------------------
// sprite_layer_mapper
// Resolves NUM_LAYERS sprite layers plus NUM_BULLETS vertical-line bullets
// into one 24-bit pixel with fixed priority (bullet > lowest opaque layer >
// background) through a two-stage registered pipeline. Layer 0 (the player)
// blinks for HIT_FRAMES frames after a hit.
// Ports:
//   Clk   - pixel clock
//   Reset - synchronous, active-high
//   bus   - sprite_layer_mapper_if.slave (pixel inputs, RGB/blink outputs)
// Optional feature macro: SCANLINE_DIM_EN -- halves every channel on odd rows.
// ----------------------------------------------------------------------------
module sprite_layer_mapper #(
    parameter int NUM_LAYERS   = 4,
    parameter int NUM_BULLETS  = 4,
    parameter int BULLET_LEN   = 4,
    parameter int HIT_FRAMES   = 64,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sprite_layer_mapper_if.slave  bus
);
    localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int BLINK_BIT = $clog2(BLINK_FRAMES);

    // Halve each 8-bit channel (scanline darkening)
    function automatic logic [23:0] dim_pixel(input logic [23:0] p);
        return {1'b0, p[23:17], 1'b0, p[15:9], 1'b0, p[7:1]};
    endfunction

    logic              bullet_hit_s;
    logic              first_hit_s;
    logic [LW-1:0]     first_idx_s;
    logic [23:0]       first_color_s;
    logic              alt_hit_s;
    logic [23:0]       alt_color_s;

    logic              s1_valid_r;
    logic              s1_bullet_r;
    logic              s1_layer_hit_r;
    logic [LW-1:0]     s1_win_idx_r;
    logic [23:0]       s1_win_color_r;
    logic              s1_alt_hit_r;
    logic [23:0]       s1_alt_color_r;
`ifdef SCANLINE_DIM_EN
    logic              s1_row_odd_r;
`endif

    logic [7:0]        hit_cnt_r;
    logic              blink_hide_s;
    logic [23:0]       pix_s;
    logic [23:0]       out_s;

    // Stage-1 bullet test: column match and row offset inside the bullet,
    // using a wrapping 10-bit difference so rows above the bullet miss.
    always_comb begin
        bullet_hit_s = 1'b0;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            bullet_hit_s = bullet_hit_s |
                (bus.bullet_active[k] &&
                 (bus.DrawX == bus.bulletX[10*k +: 10]) &&
                 (10'(bus.DrawY - bus.bulletY[10*k +: 10]) < 10'(BULLET_LEN)));
        end
    end

    // Stage-1 layer winners: scanning downward leaves the lowest opaque index.
    // The alternate winner (lowest opaque index >= 1) is what shows through
    // when layer 0 is blinked out.
    always_comb begin
        first_hit_s   = 1'b0;
        first_idx_s   = '0;
        first_color_s = 24'h000000;
        alt_hit_s     = 1'b0;
        alt_color_s   = 24'h000000;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            first_hit_s   = first_hit_s | bus.layer_on[i];
            first_idx_s   = bus.layer_on[i] ? LW'(i) : first_idx_s;
            first_color_s = bus.layer_on[i] ? bus.layer_color[24*i +: 24] : first_color_s;
        end
        for (int i = NUM_LAYERS - 1; i >= 1; i--) begin
            alt_hit_s   = alt_hit_s | bus.layer_on[i];
            alt_color_s = bus.layer_on[i] ? bus.layer_color[24*i +: 24] : alt_color_s;
        end
    end

    // Stage-1 pipeline registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_r     <= 1'b0;
            s1_bullet_r    <= 1'b0;
            s1_layer_hit_r <= 1'b0;
            s1_win_idx_r   <= '0;
            s1_win_color_r <= 24'h000000;
            s1_alt_hit_r   <= 1'b0;
            s1_alt_color_r <= 24'h000000;
`ifdef SCANLINE_DIM_EN
            s1_row_odd_r   <= 1'b0;
`endif
        end else begin
            s1_valid_r     <= bus.pixel_valid;
            s1_bullet_r    <= bullet_hit_s;
            s1_layer_hit_r <= first_hit_s;
            s1_win_idx_r   <= first_idx_s;
            s1_win_color_r <= first_color_s;
            s1_alt_hit_r   <= alt_hit_s;
            s1_alt_color_r <= alt_color_s;
`ifdef SCANLINE_DIM_EN
            s1_row_odd_r   <= bus.DrawY[0];
`endif
        end
    end

    // Hit counter: a hit (re)loads, each frame start counts down to zero.
    // blinking tracks the next counter value so both change on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_cnt_r    <= 8'd0;
            bus.blinking <= 1'b0;
        end else if (bus.hit_pulse) begin
            hit_cnt_r    <= 8'(HIT_FRAMES);
            bus.blinking <= 1'b1;
        end else if (bus.frame_start && (hit_cnt_r != 8'd0)) begin
            hit_cnt_r    <= hit_cnt_r - 8'd1;
            bus.blinking <= (hit_cnt_r != 8'd1);
        end else begin
            hit_cnt_r    <= hit_cnt_r;
            bus.blinking <= bus.blinking;
        end
    end

    assign blink_hide_s = (hit_cnt_r != 8'd0) && hit_cnt_r[BLINK_BIT];

    // Stage-2 priority selection, with the hidden player falling through
    always_comb begin
        pix_s = 24'h000000;
        if (!s1_valid_r) begin
            pix_s = 24'h000000;
        end else if (s1_bullet_r) begin
            pix_s = bus.bullet_color;
        end else if (s1_layer_hit_r && !((s1_win_idx_r == LW'(0)) && blink_hide_s)) begin
            pix_s = s1_win_color_r;
        end else if (s1_layer_hit_r && s1_alt_hit_r) begin
            pix_s = s1_alt_color_r;
        end else begin
            pix_s = bus.bg_color;
        end
    end

    // Optional odd-row darkening after selection
    always_comb begin
        out_s = pix_s;
`ifdef SCANLINE_DIM_EN
        if (s1_row_odd_r) begin
            out_s = dim_pixel(pix_s);
        end else begin
            out_s = pix_s;
        end
`endif
    end

    // Stage-2 output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.Red       <= 8'd0;
            bus.Green     <= 8'd0;
            bus.Blue      <= 8'd0;
            bus.rgb_valid <= 1'b0;
        end else begin
            bus.Red       <= out_s[23:16];
            bus.Green     <= out_s[15:8];
            bus.Blue      <= out_s[7:0];
            bus.rgb_valid <= s1_valid_r;
        end
    end
endmodule

// File: tb/tb_sprite_layer_mapper.sv
module tb_sprite_layer_mapper;
    localparam int NL    = 4;
    localparam int NB    = 4;
    localparam int LEN   = 4;
    localparam int HIT   = 64;
    localparam int BLINK = 8;

    logic Clk;
    logic Reset;
    int   cyc;
    int   errors;
    int   checks;
    int   model_cnt;

    typedef struct {
        logic [23:0] rgb;
        int          stamp;
    } exp_t;
    exp_t exp_q[$];

    sprite_layer_mapper_if #(.NUM_LAYERS(NL), .NUM_BULLETS(NB)) bus();

    sprite_layer_mapper #(
        .NUM_LAYERS(NL), .NUM_BULLETS(NB), .BULLET_LEN(LEN),
        .HIT_FRAMES(HIT), .BLINK_FRAMES(BLINK)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference pixel from the current inputs and the given counter value
    function automatic logic [23:0] ref_pixel(input int cnt);
        logic [23:0] c;
        bit hide, bhit, found;
        int x, y, bx, by;
        if (!bus.pixel_valid) return 24'h000000;
        x = int'(bus.DrawX);
        y = int'(bus.DrawY);
        hide = (cnt != 0) && (((cnt / BLINK) % 2) == 1);
        c = bus.bg_color;
        bhit = 0;
        found = 0;
        for (int k = 0; k < NB; k++) begin
            bx = int'(bus.bulletX[10*k +: 10]);
            by = int'(bus.bulletY[10*k +: 10]);
            if (bus.bullet_active[k] && bx == x && ((y - by + 1024) % 1024) < LEN) bhit = 1;
        end
        if (bhit) c = bus.bullet_color;
        else begin
            for (int i = 0; i < NL; i++) begin
                if (!found && bus.layer_on[i] && !(i == 0 && hide)) begin
                    c = bus.layer_color[24*i +: 24];
                    found = 1;
                end
            end
        end
`ifdef SCANLINE_DIM_EN
        if (y % 2 == 1) c = {c[23:16] / 8'd2, c[15:8] / 8'd2, c[7:0] / 8'd2};
`endif
        return c;
    endfunction

    // One pixel clock: update the model counter, queue the expectation,
    // advance to the next drive point and check the blink flag.
    task automatic step();
        if (Reset) model_cnt = 0;
        else if (bus.hit_pulse) model_cnt = HIT;
        else if (bus.frame_start && model_cnt > 0) model_cnt = model_cnt - 1;
        if (!Reset && bus.pixel_valid) begin
            exp_t e;
            e.rgb = ref_pixel(model_cnt);
            e.stamp = cyc;
            exp_q.push_back(e);
        end
        @(negedge Clk);
        checks++;
        if (bus.blinking !== (model_cnt != 0)) begin
            errors++;
            $display("FAIL blinking: got %b expected %b (cnt=%0d)", bus.blinking, model_cnt != 0, model_cnt);
        end
        bus.hit_pulse = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic set_pix(input int x, input int y, input bit v);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.pixel_valid = v;
    endtask

    // Monitor: pops on every valid output, otherwise expects black
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (bus.rgb_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel: got %h expected none", {bus.Red, bus.Green, bus.Blue});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({bus.Red, bus.Green, bus.Blue} !== e.rgb || (cyc - e.stamp) != 2) begin
                        errors++;
                        $display("FAIL pixel: got %h latency %0d expected %h latency 2",
                                 {bus.Red, bus.Green, bus.Blue}, cyc - e.stamp, e.rgb);
                    end
                end
            end else begin
                checks++;
                if ({bus.Red, bus.Green, bus.Blue} !== 24'h000000 || bus.rgb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_black: got %h valid %b expected 000000 valid 0",
                             {bus.Red, bus.Green, bus.Blue}, bus.rgb_valid);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        errors = 0;
        checks = 0;
        model_cnt = 0;
        Reset = 1'b1;
        set_pix(0, 0, 1'b1);
        bus.hit_pulse = 1'b0;
        bus.frame_start = 1'b0;
        bus.layer_on = '1;
        for (int i = 0; i < NL; i++) bus.layer_color[24*i +: 24] = 24'(32'h101010 * (i + 1));
        bus.bullet_active = '0;
        bus.bulletX = '0;
        bus.bulletY = '0;
        bus.bullet_color = 24'hABCDEF;
        bus.bg_color = 24'h123456;

        // Reset held with valid pixels and all layers opaque
        for (int i = 0; i < 3; i++) step();
        Reset = 1'b0;

        // Bullet slot 2 at (100,50), only layer 0 opaque
        bus.layer_on = 4'b0001;
        bus.bullet_active = 4'b0100;
        bus.bulletX[20 +: 10] = 10'd100;
        bus.bulletY[20 +: 10] = 10'd50;
        for (int y = 49; y <= 54; y++) begin
            set_pix(100, y, 1'b1);
            step();
        end
        set_pix(101, 51, 1'b1);
        step();
        bus.bullet_active = '0;

        // Layer priority, background, blanking
        bus.layer_color[24 +: 24] = 24'hFF0000;
        bus.layer_color[48 +: 24] = 24'h00FF00;
        bus.layer_on = 4'b0110;
        set_pix(5, 5, 1'b1);
        step();
        bus.layer_on = 4'b0000;
        step();
        set_pix(5, 5, 1'b0);
        step();
        step();

        // Blink sequence on layer 0 over layer 1
        bus.layer_on = 4'b0011;
        set_pix(10, 10, 1'b1);
        bus.hit_pulse = 1'b1;
        step();
        step();
        for (int f = 0; f < 70; f++) begin
            bus.frame_start = 1'b1;
            step();
            step();
        end

        // Load beats decrement; decrement stops at zero
        bus.hit_pulse = 1'b1;
        step();
        for (int f = 0; f < HIT - 10; f++) begin
            bus.frame_start = 1'b1;
            step();
        end
        bus.hit_pulse = 1'b1;
        bus.frame_start = 1'b1;
        step();
        step();
        for (int f = 0; f < HIT + 3; f++) begin
            bus.frame_start = 1'b1;
            step();
        end

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            set_pix($urandom_range(0, 7),
                    ($urandom_range(0, 3) == 0) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, 15),
                    $urandom_range(0, 7) != 0);
            bus.layer_on = NL'($urandom);
            for (int i = 0; i < NL; i++) bus.layer_color[24*i +: 24] = 24'($urandom);
            bus.bullet_active = NB'($urandom);
            for (int k = 0; k < NB; k++) begin
                bus.bulletX[10*k +: 10] = 10'($urandom_range(0, 7));
                bus.bulletY[10*k +: 10] = ($urandom_range(0, 3) == 0) ?
                    10'(1020 + $urandom_range(0, 3)) : 10'($urandom_range(0, 15));
            end
            bus.hit_pulse = ($urandom_range(0, 79) == 0);
            bus.frame_start = ($urandom_range(0, 2) == 0);
            step();
        end

        // Drain the pipeline
        set_pix(0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
